pe_array_systolic: RTL

Output-stationary M×N systolic multiply-accumulate array: the parametrised successor to the flat PE grid behind the `tt_um_pe_*` top level. Each accepted beat supplies one M-element column vector A and one N-element row vector B. PE(i,j) accumulates A[i]·B[j] across a tile, under a per-tile precision mode. After the last beat the array flushes its internal skew, then drains all M·N results row-major over a valid/ready port. It sits between the input-packing logic and the 8-bit output serialiser of the top level.

---
 rtl/pe_array_systolic.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_array_systolic.sv
// ============================================================================
// Module      : pe_array_systolic
// Description : Output-stationary M x N systolic multiply-accumulate array.
//               A column vector A and a row vector B enter per beat; PE(i,j)
//               accumulates A[i]*B[j] over a tile in the latched precision
//               mode, the skew pipeline is flushed, then all M*N results
//               drain row-major over a valid/ready port.
//               Optional feature macro: PE_ARRAY_SATURATE_EN (clamping
//               accumulators instead of two's-complement wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_array_systolic #(
  parameter int M            = 2,
  parameter int N            = 2,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [M*INPUT_WIDTH-1:0]  a_in,
  input  logic [N*INPUT_WIDTH-1:0]  b_in,
  input  logic [1:0]                precision_mode,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [OUTPUT_WIDTH-1:0]   out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int c_w         = INPUT_WIDTH;
  localparam int c_ow        = OUTPUT_WIDTH;
  localparam int c_h         = INPUT_WIDTH / 2;
  localparam int c_mn        = M * N;
  localparam int c_idxw      = (c_mn > 1) ? $clog2(c_mn) : 1;
  localparam int c_flush_len = M + N - 1;
  localparam int c_fcw       = $clog2(M + N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    FLUSH   = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [c_fcw-1:0]    r_flush_cnt;
  logic [c_idxw-1:0]   r_idx;
  logic [c_idxw-1:0]   w_idx_next;
  logic                w_accept;
  logic                w_start;

  // Operands and valid bits arriving at each PE, flattened as i*N+j
  logic [c_w-1:0]      w_pe_a  [c_mn];
  logic [c_w-1:0]      w_pe_b  [c_mn];
  logic                w_pe_av [c_mn];
  logic                w_pe_bv [c_mn];
  logic [c_ow-1:0]     w_acc   [c_mn];

  assign in_ready   = (r_state == IDLE) || (r_state == COMPUTE);
  assign busy       = (r_state != IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_start    = w_accept && (r_state == IDLE);
  assign w_idx_next = r_idx + 1'b1;

  // Product of one operand pair, already extended to accumulator width.
  // All arithmetic is done modulo 2^c_ow, which is exact because every
  // mode's true product fits in c_ow bits.
  function automatic logic [c_ow-1:0] pe_product(input logic [c_w-1:0] a,
                                                 input logic [c_w-1:0] b,
                                                 input logic [1:0]     mode);
    logic [c_ow-1:0] p;
    case (mode)
      2'b01:   p = c_ow'(a) * c_ow'(b);
      2'b10:   p = c_ow'($signed(a[c_w-1:c_h])) * c_ow'($signed(b[c_w-1:c_h]))
                 + c_ow'($signed(a[c_h-1:0]))   * c_ow'($signed(b[c_h-1:0]));
      default: p = c_ow'($signed(a)) * c_ow'($signed(b));
    endcase
    return p;
  endfunction

`ifdef PE_ARRAY_SATURATE_EN
  // Clamping add: unsigned clamps on carry-out, signed clamps when two
  // same-signed operands produce a result of the opposite sign.
  function automatic logic [c_ow-1:0] acc_sat(input logic [c_ow-1:0] acc,
                                              input logic [c_ow-1:0] prod,
                                              input logic            uns);
    logic [c_ow:0]   wide;
    logic [c_ow-1:0] sum;
    wide = {1'b0, acc} + {1'b0, prod};
    sum  = wide[c_ow-1:0];
    if (uns) begin
      return wide[c_ow] ? {c_ow{1'b1}} : sum;
    end
    if ((acc[c_ow-1] == prod[c_ow-1]) && (sum[c_ow-1] != acc[c_ow-1])) begin
      return acc[c_ow-1] ? {1'b1, {(c_ow-1){1'b0}}} : {1'b0, {(c_ow-1){1'b1}}};
    end
    return sum;
  endfunction
`endif

  // Tile control: accept beats, count down the skew flush, drain results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= 2'b00;
      r_flush_cnt <= '0;
      r_idx       <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode <= precision_mode;
            if (in_last) begin
              r_state     <= FLUSH;
              r_flush_cnt <= c_fcw'(c_flush_len);
            end else begin
              r_state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (w_accept && in_last) begin
            r_state     <= FLUSH;
            r_flush_cnt <= c_fcw'(c_flush_len);
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state   <= DRAIN;
            r_idx     <= '0;
            out_valid <= 1'b1;
            out_data  <= w_acc[0];
            out_last  <= (c_mn == 1);
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              r_state   <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              r_idx    <= w_idx_next;
              out_data <= w_acc[w_idx_next];
              out_last <= (w_idx_next == c_idxw'(c_mn - 1));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Row i of A: i cycles of skew, then one hop per PE moving right
  for (genvar gi = 0; gi < M; gi++) begin : g_arow
    localparam int c_len = gi + N;
    logic [c_w-1:0] r_sr [c_len];
    logic           r_sv [c_len];

    // Shift A data and valid along the row each cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < c_len; k++) begin
          r_sr[k] <= '0;
          r_sv[k] <= 1'b0;
        end
      end else begin
        r_sv[0] <= w_accept;
        if (w_accept) r_sr[0] <= a_in[gi*c_w +: c_w];
        for (int k = 1; k < c_len; k++) begin
          r_sr[k] <= r_sr[k-1];
          r_sv[k] <= r_sv[k-1];
        end
      end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_tap
      assign w_pe_a[gi*N+gj]  = r_sr[gi+gj];
      assign w_pe_av[gi*N+gj] = r_sv[gi+gj];
    end
  end

  // Column j of B: j cycles of skew, then one hop per PE moving down
  for (genvar gj = 0; gj < N; gj++) begin : g_bcol
    localparam int c_len = gj + M;
    logic [c_w-1:0] r_sr [c_len];
    logic           r_sv [c_len];

    // Shift B data and valid down the column each cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < c_len; k++) begin
          r_sr[k] <= '0;
          r_sv[k] <= 1'b0;
        end
      end else begin
        r_sv[0] <= w_accept;
        if (w_accept) r_sr[0] <= b_in[gj*c_w +: c_w];
        for (int k = 1; k < c_len; k++) begin
          r_sr[k] <= r_sr[k-1];
          r_sv[k] <= r_sv[k-1];
        end
      end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_tap
      assign w_pe_b[gi*N+gj]  = r_sr[gi+gj];
      assign w_pe_bv[gi*N+gj] = r_sv[gi+gj];
    end
  end

  // Processing elements: one accumulator each
  for (genvar gi = 0; gi < M; gi++) begin : g_pe_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe_col
      localparam int c_k = gi * N + gj;
      logic [c_ow-1:0] r_acc;
      logic [c_ow-1:0] w_prod;
      logic [c_ow-1:0] w_sum;

      // Next accumulator value for the operand pair currently at this PE
      always_comb begin
        w_prod = pe_product(w_pe_a[c_k], w_pe_b[c_k], r_mode);
`ifdef PE_ARRAY_SATURATE_EN
        w_sum  = acc_sat(r_acc, w_prod, (r_mode == 2'b01));
`else
        w_sum  = r_acc + w_prod;
`endif
      end

      // Clear at tile start, accumulate only on valid operand slots
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (w_start) begin
          r_acc <= '0;
        end else if (w_pe_av[c_k] && w_pe_bv[c_k]) begin
          r_acc <= w_sum;
        end
      end

      assign w_acc[c_k] = r_acc;
    end
  end

endmodule

`default_nettype wire
